liteic_master_node_read: RTL and testbench

LITEIC_MASTER_NODE_READ -- requirements
Module: liteic_master_node_read

---
 rtl/liteic_master_node_read_if.sv | 36 +++
 rtl/liteic_master_node_read.sv | 75 +++++++
 tb/tb_liteic_master_node_read.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/liteic_master_node_read_if.sv
// liteic_master_node_read_if: bus bundle for a master read node.
//   master modport: the node's view (AR/R toward the bus master, request/response toward the crossbar).
//   slave  modport: the environment's view (the bus master plus the crossbar slave nodes).
interface liteic_master_node_read_if #(
   parameter int IC_NUM_SLAVE_SLOTS = 4,
   parameter int IC_ARADDR_WIDTH    = 32,
   parameter int IC_DATA_WIDTH      = 32
);
   logic [IC_ARADDR_WIDTH-1:0]    m_ar_addr_i;
   logic [3:0]                    m_ar_qos_i;
   logic                          m_ar_valid_i;
   logic                          m_ar_ready_o;
   logic [IC_DATA_WIDTH-1:0]      m_r_data_o;
   logic [1:0]                    m_r_resp_o;
   logic                          m_r_valid_o;
   logic                          m_r_ready_i;
   logic [IC_ARADDR_WIDTH-1:0]    cbar_reqst_data_o;
   logic [3:0]                    cbar_reqst_arqos_o;
   logic [IC_NUM_SLAVE_SLOTS-1:0] cbar_reqst_val_o;
   logic [IC_NUM_SLAVE_SLOTS-1:0] cbar_reqst_rdy_i;
   logic [IC_NUM_SLAVE_SLOTS-1:0] cbar_resp_val_i;
   logic [IC_NUM_SLAVE_SLOTS-1:0] cbar_resp_rdy_o;
   logic [IC_DATA_WIDTH+1:0]      cbar_resp_data_i [IC_NUM_SLAVE_SLOTS];
   modport master (
      input  m_ar_addr_i, m_ar_qos_i, m_ar_valid_i, m_r_ready_i,
             cbar_reqst_rdy_i, cbar_resp_val_i, cbar_resp_data_i,
      output m_ar_ready_o, m_r_data_o, m_r_resp_o, m_r_valid_o,
             cbar_reqst_data_o, cbar_reqst_arqos_o, cbar_reqst_val_o, cbar_resp_rdy_o
   );
   modport slave (
      output m_ar_addr_i, m_ar_qos_i, m_ar_valid_i, m_r_ready_i,
             cbar_reqst_rdy_i, cbar_resp_val_i, cbar_resp_data_i,
      input  m_ar_ready_o, m_r_data_o, m_r_resp_o, m_r_valid_o,
             cbar_reqst_data_o, cbar_reqst_arqos_o, cbar_reqst_val_o, cbar_resp_rdy_o
   );
endinterface

// File: rtl/liteic_master_node_read.sv
// liteic_master_node_read: single-outstanding read master node; decodes AR to a crossbar slave, forwards R, answers DECERR on unmapped addresses.
//   clk_i        clock, rising edge
//   rstn_i       asynchronous active-low reset
//   bus          liteic_master_node_read_if.master (master AR/R, crossbar request/response)
//   decerr_cnt_o saturating 8-bit count of decode errors
module liteic_master_node_read #(
   parameter int IC_NUM_SLAVE_SLOTS = 4,
   parameter int IC_ARADDR_WIDTH    = 32,
   parameter int IC_DATA_WIDTH      = 32,
   parameter logic [IC_ARADDR_WIDTH-1:0] SLV_BASE [IC_NUM_SLAVE_SLOTS] =
      '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000},
   parameter logic [IC_ARADDR_WIDTH-1:0] SLV_MASK [IC_NUM_SLAVE_SLOTS] =
      '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   liteic_master_node_read_if.master bus,
   output logic [7:0]               decerr_cnt_o
);
   localparam int NS = IC_NUM_SLAVE_SLOTS;
   localparam int IW = (NS > 1) ? $clog2(NS) : 1;
   typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;
   state_t                     state_q, state_d;
   logic [IC_ARADDR_WIDTH-1:0] addr_q;
   logic [3:0]                 qos_q;
   logic [IW-1:0]              sel_q, idx;
   logic                       hit, accept;
   logic [NS-1:0]              sel_oh;
   // Scan from the top so the lowest matching index is the one left in idx.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = NS - 1; i >= 0; i--)
         if ((bus.m_ar_addr_i & SLV_MASK[i]) == SLV_BASE[i]) begin
            hit = 1'b1;
            idx = i[IW-1:0];
         end
   end
   assign accept = (state_q == IDLE) && bus.m_ar_valid_i;
   assign sel_oh = NS'(1) << sel_q;
   always_comb begin
      state_d                = state_q;
      bus.m_ar_ready_o       = state_q == IDLE;
      bus.cbar_reqst_data_o  = (state_q == IDLE) ? '0 : addr_q;
      bus.cbar_reqst_arqos_o = (state_q == IDLE) ? '0 : qos_q;
      bus.cbar_reqst_val_o   = (state_q == REQ) ? sel_oh : '0;
      bus.cbar_resp_rdy_o    = (state_q == RESP && bus.m_r_ready_i) ? sel_oh : '0;
      bus.m_r_valid_o        = (state_q == RESP) ? bus.cbar_resp_val_i[sel_q] : state_q == ERR;
      {bus.m_r_data_o, bus.m_r_resp_o} = (state_q == RESP) ? bus.cbar_resp_data_i[sel_q] :
                                         (state_q == ERR)  ? {{IC_DATA_WIDTH{1'b0}}, 2'b11} : '0;
      case (state_q)
         IDLE:    state_d = accept ? (hit ? REQ : ERR) : IDLE;
         REQ:     state_d = bus.cbar_reqst_rdy_i[sel_q] ? RESP : REQ;
         RESP:    state_d = (bus.m_r_valid_o && bus.m_r_ready_i) ? IDLE : RESP;
         default: state_d = bus.m_r_ready_i ? IDLE : ERR;
      endcase
   end
   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         qos_q        <= '0;
         sel_q        <= '0;
         decerr_cnt_o <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q <= bus.m_ar_addr_i;
            qos_q  <= bus.m_ar_qos_i;
            sel_q  <= idx;
         end
         if (accept && !hit && decerr_cnt_o != 8'hFF)
            decerr_cnt_o <= decerr_cnt_o + 8'd1;
      end
endmodule

// File: tb/tb_liteic_master_node_read.sv
// tb_liteic_master_node_read: directed self-checking bench for liteic_master_node_read.
module tb_liteic_master_node_read;
   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] cnt;
   int         tests = 0;
   int         failed = 0;
   liteic_master_node_read_if #(.IC_NUM_SLAVE_SLOTS(4), .IC_ARADDR_WIDTH(32), .IC_DATA_WIDTH(32)) bus ();
   liteic_master_node_read dut (.clk_i(clk), .rstn_i(rstn), .bus(bus), .decerr_cnt_o(cnt));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic nxt();
      @(negedge clk);
   endtask
   task automatic ar(input logic [31:0] a, input logic [3:0] q);
      bus.m_ar_addr_i  = a;
      bus.m_ar_qos_i   = q;
      bus.m_ar_valid_i = 1'b1;
   endtask
   task automatic clr();
      bus.m_ar_valid_i     = 1'b0;
      bus.m_r_ready_i      = 1'b0;
      bus.cbar_reqst_rdy_i = '0;
      bus.cbar_resp_val_i  = '0;
      for (int i = 0; i < 4; i++) bus.cbar_resp_data_i[i] = '0;
   endtask
   initial begin
      bus.m_ar_addr_i = '0;
      bus.m_ar_qos_i  = '0;
      clr();
      nxt(); nxt();
      #1;
      chk("rst_ar_ready", bus.m_ar_ready_o, 1);
      chk("rst_r_valid", bus.m_r_valid_o, 0);
      chk("rst_reqst_val", bus.cbar_reqst_val_o, 0);
      chk("rst_cnt", cnt, 0);
      // Slave 1 read, rdy arrives in the 4th REQ cycle, other slaves' rdy is noise
      nxt(); rstn = 1'b1;
      ar(32'h1000_0040, 4'h5);
      #1 chk("t1_ar_ready", bus.m_ar_ready_o, 1);
      for (int k = 0; k < 4; k++) begin
         nxt();
         bus.m_ar_valid_i = 1'b0;
         bus.cbar_reqst_rdy_i = (k == 3) ? 4'b0010 : 4'b1101;
         #1;
         chk("t1_reqst_val", bus.cbar_reqst_val_o, 4'b0010);
         chk("t1_reqst_data", bus.cbar_reqst_data_o, 32'h1000_0040);
         chk("t1_reqst_qos", bus.cbar_reqst_arqos_o, 4'h5);
         chk("t1_ar_ready_busy", bus.m_ar_ready_o, 0);
      end
      nxt();
      bus.cbar_reqst_rdy_i = '0;
      bus.cbar_resp_val_i = 4'b0010;
      bus.cbar_resp_data_i[1] = {32'hCAFE_F00D, 2'b00};
      bus.m_r_ready_i = 1'b1;
      #1;
      chk("t1_val_dropped", bus.cbar_reqst_val_o, 0);
      chk("t1_r_valid", bus.m_r_valid_o, 1);
      chk("t1_r_data", bus.m_r_data_o, 32'hCAFE_F00D);
      chk("t1_r_resp", bus.m_r_resp_o, 0);
      chk("t1_resp_rdy", bus.cbar_resp_rdy_o, 4'b0010);
      nxt(); clr();
      #1;
      chk("t1_idle_ar_ready", bus.m_ar_ready_o, 1);
      chk("t1_idle_r_valid", bus.m_r_valid_o, 0);
      // Unmapped read: DECERR one cycle after accept, held while r_ready low
      ar(32'h4000_0000, 4'h0);
      nxt();
      bus.m_ar_valid_i = 1'b0;
      #1;
      chk("t2_r_valid", bus.m_r_valid_o, 1);
      chk("t2_r_resp", bus.m_r_resp_o, 2'b11);
      chk("t2_r_data", bus.m_r_data_o, 0);
      chk("t2_reqst_val", bus.cbar_reqst_val_o, 0);
      chk("t2_cnt", cnt, 1);
      nxt(); #1;
      chk("t2_hold_valid", bus.m_r_valid_o, 1);
      chk("t2_hold_ar_ready", bus.m_ar_ready_o, 0);
      bus.m_r_ready_i = 1'b1;
      nxt(); #1;
      chk("t2_done_ar_ready", bus.m_ar_ready_o, 1);
      chk("t2_done_r_valid", bus.m_r_valid_o, 0);
      // 299 more back-to-back unmapped reads: two cycles each, counter saturates
      ar(32'hF000_0000, 4'h0);
      for (int k = 0; k < 20; k++) nxt();
      #1 chk("t3_cnt_mid", cnt, 11);
      for (int k = 0; k < 578; k++) nxt();
      #1 chk("t3_cnt_pre", cnt, 255);
      chk("t3_reqst_val", bus.cbar_reqst_val_o, 0);
      clr();
      nxt(); nxt(); #1;
      chk("t3_cnt_sat", cnt, 255);
      chk("t3_idle", bus.m_ar_ready_o, 1);
      // Slave 2 response stalled 5 cycles by master
      ar(32'h2000_0000, 4'h3);
      nxt();
      bus.m_ar_valid_i = 1'b0;
      bus.cbar_reqst_rdy_i = 4'b0100;
      #1 chk("t4_reqst_val", bus.cbar_reqst_val_o, 4'b0100);
      nxt();
      bus.cbar_reqst_rdy_i = '0;
      bus.cbar_resp_val_i = 4'b0100;
      bus.cbar_resp_data_i[2] = {32'h1234_5678, 2'b01};
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t4_stall_valid", bus.m_r_valid_o, 1);
         chk("t4_stall_rdy", bus.cbar_resp_rdy_o, 0);
         chk("t4_stall_data", bus.m_r_data_o, 32'h1234_5678);
         nxt();
      end
      bus.m_r_ready_i = 1'b1;
      #1;
      chk("t4_fin_rdy", bus.cbar_resp_rdy_o, 4'b0100);
      chk("t4_fin_resp", bus.m_r_resp_o, 2'b01);
      nxt(); clr();
      #1 chk("t4_idle", bus.m_ar_ready_o, 1);
      // Slave 3 read with spurious slave 0 response valid throughout
      bus.cbar_resp_val_i = 4'b0001;
      bus.cbar_resp_data_i[0] = {32'hDEAD_BEEF, 2'b10};
      ar(32'h3000_0010, 4'h0);
      #1 chk("t5_idle_spur_valid", bus.m_r_valid_o, 0);
      nxt();
      bus.m_ar_valid_i = 1'b0;
      bus.cbar_reqst_rdy_i = 4'b1000;
      #1;
      chk("t5_reqst_val", bus.cbar_reqst_val_o, 4'b1000);
      chk("t5_req_spur_valid", bus.m_r_valid_o, 0);
      nxt();
      bus.cbar_reqst_rdy_i = '0;
      bus.cbar_resp_val_i = 4'b1001;
      bus.cbar_resp_data_i[3] = {32'hA5A5_5A5A, 2'b00};
      bus.m_r_ready_i = 1'b1;
      #1;
      chk("t5_r_data", bus.m_r_data_o, 32'hA5A5_5A5A);
      chk("t5_resp_rdy", bus.cbar_resp_rdy_o, 4'b1000);
      nxt(); bus.cbar_resp_val_i = 4'b0001;
      #1;
      chk("t5_idle_valid", bus.m_r_valid_o, 0);
      chk("t5_idle_rdy", bus.cbar_resp_rdy_o, 0);
      clr();
      // Reset mid-RESP, then a normal slave 2 read
      ar(32'h2000_0000, 4'h7);
      nxt();
      bus.m_ar_valid_i = 1'b0;
      bus.cbar_reqst_rdy_i = 4'b0100;
      nxt();
      bus.cbar_reqst_rdy_i = '0;
      #1 chk("t6_in_resp", bus.m_ar_ready_o, 0);
      rstn = 1'b0;
      #1;
      chk("t6_rst_ar_ready", bus.m_ar_ready_o, 1);
      chk("t6_rst_cnt", cnt, 0);
      chk("t6_rst_data", bus.cbar_reqst_data_o, 0);
      chk("t6_rst_resp_rdy", bus.cbar_resp_rdy_o, 0);
      nxt();
      rstn = 1'b1;
      ar(32'h2000_0000, 4'h0);
      nxt();
      bus.m_ar_valid_i = 1'b0;
      bus.cbar_reqst_rdy_i = 4'b0100;
      #1 chk("t6_reqst_val", bus.cbar_reqst_val_o, 4'b0100);
      nxt();
      bus.cbar_reqst_rdy_i = '0;
      bus.cbar_resp_val_i = 4'b0100;
      bus.cbar_resp_data_i[2] = {32'h0BAD_F00D, 2'b00};
      bus.m_r_ready_i = 1'b1;
      #1;
      chk("t6_r_data", bus.m_r_data_o, 32'h0BAD_F00D);
      chk("t6_r_valid", bus.m_r_valid_o, 1);
      nxt(); clr();
      #1 chk("t6_idle", bus.m_ar_ready_o, 1);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
